// File: rtl/uart_rx_os_fifo.sv
// Oversampling UART receiver: 3-sample majority vote, framing/break detection, FWFT output FIFO.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_os_fifo #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
  output logic [PAYLOAD_BITS-1:0]       m_data,
  output logic                          m_frame_err,
  output logic                          m_parity_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          rx_break,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int unsigned DIV   = CLK_HZ / (BIT_RATE * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned S_W   = $clog2(OVERSAMPLE);
  localparam int unsigned BW    = $clog2(PAYLOAD_BITS);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
  localparam int unsigned EW    = PAYLOAD_BITS + 2;
`else
  localparam int unsigned EW    = PAYLOAD_BITS + 1;
`endif

  localparam logic [S_W-1:0] S_MID0 = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_MID1 = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0] S_MID2 = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [S_W-1:0] S_END  = S_W'(OVERSAMPLE - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StBrk    = 3'd5;

  logic                    rxd_meta_q, rxd_s_q;
  logic [DIV_W-1:0]        div_q;
  logic                    tick;
  logic [2:0]              state_q, state_d;
  logic [S_W-1:0]          s_q, s_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    stop_q, stop_d;
  logic                    v0_q, v0_d, v1_q, v1_d;
  logic                    vote;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic                    ferr_q, ferr_d;
  logic                    par_q, par_d;
  logic                    brk_frame;
  logic                    push_q, push_d;
  logic                    brk_q, brk_d;

  assign tick = uart_rx_en && (div_q == DIV_W'(DIV - 1));
  assign vote = (v0_q & v1_q) | (v0_q & rxd_s_q) | (v1_q & rxd_s_q);

`ifdef UART_RX_PARITY_EN
  assign brk_frame = ~|shreg_q & ~vote & ~par_q;
`else
  assign brk_frame = ~|shreg_q & ~vote;
  logic unused_cfg;
  assign unused_cfg = ^{PARITY_ODD, StParity, par_q};
`endif

  always_comb begin
    state_d = state_q;
    s_d     = (s_q == S_END) ? '0 : s_q + S_W'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    shreg_d = shreg_q;
    ferr_d  = ferr_q;
    par_d   = par_q;
    push_d  = 1'b0;
    brk_d   = 1'b0;
    if (!uart_rx_en) begin
      state_d = StIdle;
      s_d     = s_q;
    end else if (!tick) begin
      s_d = s_q;
    end else begin
      if (s_q == S_MID0) v0_d = rxd_s_q;
      if (s_q == S_MID1) v1_d = rxd_s_q;
      case (state_q)
        StIdle: begin
          if (!rxd_s_q) begin
            state_d = StStart;
            s_d     = '0;
          end
        end
        StStart: begin
          if (s_q == S_MID2 && vote) begin
            state_d = StIdle;
          end else if (s_q == S_END) begin
            state_d = StData;
            bit_d   = '0;
          end
        end
        StData: begin
          if (s_q == S_MID2) shreg_d = {vote, shreg_q[PAYLOAD_BITS-1:1]};
          if (s_q == S_END) begin
            if (bit_q == BW'(PAYLOAD_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
              stop_d = 1'b0;
              ferr_d = 1'b0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        StParity: begin
          if (s_q == S_MID2) par_d = vote;
          if (s_q == S_END) state_d = StStop;
        end
        StStop: begin
          // Completes at the last stop bit's vote so the next start edge is never missed.
          if (s_q == S_MID2) begin
            if (!stop_q) ferr_d = ~vote;
            if (stop_q == STOP_LAST) begin
              if (brk_frame) begin
                state_d = StBrk;
                s_d     = '0;
                brk_d   = 1'b1;
              end else begin
                state_d = StIdle;
                push_d  = 1'b1;
              end
            end
          end else if (s_q == S_END) begin
            stop_d = 1'b1;
          end
        end
        StBrk: begin
          // s counts consecutive high samples here.
          if (!rxd_s_q) s_d = '0;
          else if (s_q == S_END) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      div_q      <= '0;
      state_q    <= StIdle;
      s_q        <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      v0_q       <= 1'b1;
      v1_q       <= 1'b1;
      shreg_q    <= '0;
      ferr_q     <= 1'b0;
      par_q      <= 1'b0;
      push_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
      div_q      <= (!uart_rx_en || tick) ? '0 : div_q + DIV_W'(1);
      state_q    <= state_d;
      s_q        <= s_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      shreg_q    <= shreg_d;
      ferr_q     <= ferr_d;
      par_q      <= par_d;
      push_q     <= push_d;
      brk_q      <= brk_d;
    end
  end

  // Output FIFO, first-word fall-through.
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] wdata, head;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          full, pop, wr_en, ovf_q;

`ifdef UART_RX_PARITY_EN
  assign wdata = {((^shreg_q) ^ par_q) != PARITY_ODD, ferr_q, shreg_q};
`else
  assign wdata = {ferr_q, shreg_q};
`endif

  assign full  = (cnt_q == (AW + 1)'(FIFO_DEPTH));
  assign pop   = m_valid && m_ready;
  assign wr_en = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= push_q && full && !pop;
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head        = mem_q[rd_q];
  assign m_valid     = (cnt_q != '0);
  assign m_data      = m_valid ? head[PAYLOAD_BITS-1:0] : '0;
  assign m_frame_err = m_valid & head[PAYLOAD_BITS];
`ifdef UART_RX_PARITY_EN
  assign m_parity_err = m_valid & head[PAYLOAD_BITS+1];
`else
  assign m_parity_err = 1'b0;
`endif
  assign rx_break   = brk_q;
  assign overflow   = ovf_q;
  assign fifo_level = cnt_q;
  assign busy       = (state_q != StIdle);

endmodule
